// File: rtl/add_seq_ctrl_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
// Signal names are seen from the adder side (i_ = into adder).
interface add_seq_ctrl_if #(
    parameter int N_NIB = 4
);
    localparam int W = 4 * N_NIB;

    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         i_cin;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_sum;
    logic         o_cout;
    logic         o_busy;

    modport slave (
        input  i_valid,
        input  i_a,
        input  i_b,
        input  i_cin,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_sum,
        output o_cout,
        output o_busy
    );

    modport master (
        output i_valid,
        output i_a,
        output i_b,
        output i_cin,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_sum,
        input  o_cout,
        input  o_busy
    );
endinterface

// File: rtl/add_seq_ctrl.sv
// Nibble-serial adder: one 4-bit add per clock, carry rippled
// through a register; IDLE -> RUN -> DONE handshake controller.
module add_seq_ctrl #(
    parameter int N_NIB = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    add_seq_ctrl_if.slave  bus
);
    localparam int W  = 4 * N_NIB;
    localparam int IW = (N_NIB > 1) ? $clog2(N_NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [IW-1:0] r_idx;
    logic          r_carry;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_sum;
    logic          r_cout;
    logic          r_ready;
    logic          r_busy;
    logic          r_valid;

    logic [IW+1:0] w_base;
    logic [3:0]    w_a_nib;
    logic [3:0]    w_b_nib;
    logic [4:0]    w_nsum;
    logic          w_last;

    assign w_base  = {r_idx, 2'b00};
    assign w_a_nib = r_a[w_base +: 4];
    assign w_b_nib = r_b[w_base +: 4];
    assign w_nsum  = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0, r_carry};
    assign w_last  = (r_idx == IW'(N_NIB - 1));

    // Status flags are registered copies of the state decode.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.i_valid && r_ready) begin
                        r_a     <= bus.i_a;
                        r_b     <= bus.i_b;
                        r_carry <= bus.i_cin;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_idx   <= '0;
                        r_state <= RUN;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    r_sum[w_base +: 4] <= w_nsum[3:0];
                    r_carry            <= w_nsum[4];
                    // Index saturates on the last nibble; no wrap.
                    if (w_last) begin
                        r_cout  <= w_nsum[4];
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                DONE: begin
                    if (bus.i_ready) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_ready = r_ready;
    assign bus.o_busy  = r_busy;
    assign bus.o_valid = r_valid;
    assign bus.o_sum   = r_sum;
    assign bus.o_cout  = r_cout;
endmodule
